// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM access arbiter: SPI command codes, FSM states
// and requester identifiers.
package ram_arb_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_SPI  = 1'b1;

endpackage

// File: rtl/ram_arb_tx_hold.sv
// Holds tx_valid/tx_data for TX_HOLD cycles after each load so the SPI slave
// can shift the byte out; a new load restarts the hold.
module ram_arb_tx_hold
  import ram_arb_pkg::*;
#(
  parameter int TX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tx_valid,
  output logic [7:0] tx_data
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      cnt      <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
      cnt      <= CNT_W'(TX_HOLD - 1);
    end else if (tx_valid) begin
      if (cnt == '0) tx_valid <= 1'b0;
      else           cnt      <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an SPI slave and a
// local host. Optional macro RAM_ARB_AUTOINC_EN enables SPI address auto-increment.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_din,
  input  logic [7:0]           mem_dout,
  output logic                 spi_ovr
);

  state_t               state, state_nxt;
  logic                 last_gnt;
  logic                 cur_rd;
  logic                 host_req_q;
  logic                 spi_pend;
  logic                 spi_rd;
  logic [7:0]           spi_wdata;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [7:0]           rdata_q;

  logic                 grant_spi, grant_host, any_grant;
  logic                 host_pend;
  logic [1:0]           cmd;
  logic                 spi_cmd, spi_load, ld_wr, ld_rd, tx_load;
  logic [ADDR_SIZE-1:0] pay_addr, spi_addr;

  assign cmd      = rx_data[9:8];
  assign pay_addr = ADDR_SIZE'({8'h00, rx_data[7:0]});
  assign ld_wr    = rx_valid && (cmd == CMD_WR_ADDR);
  assign ld_rd    = rx_valid && (cmd == CMD_RD_ADDR);
  assign spi_cmd  = rx_valid && ((cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA));
  assign spi_load = spi_cmd && (!spi_pend || grant_spi);
  assign spi_addr = spi_rd ? rd_addr : wr_addr;
  // The host request is qualified one cycle so it contends on equal footing
  // with the registered SPI pending entry.
  assign host_pend = host_req && host_req_q;
  assign any_grant = grant_spi || grant_host;
  assign tx_load   = (state == ST_RESP) && (last_gnt == REQ_SPI);

  always_comb begin
    state_nxt  = state;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spi_pend && (!host_pend || last_gnt == REQ_HOST)) grant_spi = 1'b1;
        else if (host_pend)                                   grant_host = 1'b1;
        if (grant_spi || grant_host) state_nxt = ST_ACCESS;
      end
      ST_ACCESS:  state_nxt = cur_rd ? ST_RD_WAIT : ST_IDLE;
      ST_RD_WAIT: state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_gnt    <= REQ_HOST;
      cur_rd      <= 1'b0;
      host_req_q  <= 1'b0;
      spi_pend    <= 1'b0;
      spi_ovr     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= 8'h00;
    end else begin
      state      <= state_nxt;
      host_req_q <= host_req;

      // Grant stage: RAM port signals are registered here and live for ACCESS only
      mem_en   <= any_grant;
      mem_we   <= (grant_spi && !spi_rd) || (grant_host && host_we);
      mem_addr <= grant_spi ? spi_addr : (grant_host ? host_addr : '0);
      mem_din  <= (grant_spi && !spi_rd) ? spi_wdata :
                  ((grant_host && host_we) ? host_wdata : 8'h00);
      host_gnt <= grant_host;
      if (any_grant) begin
        last_gnt <= grant_spi ? REQ_SPI : REQ_HOST;
        cur_rd   <= grant_spi ? spi_rd : !host_we;
      end

      host_rvalid <= (state == ST_RESP) && (last_gnt == REQ_HOST);
      if ((state == ST_RESP) && (last_gnt == REQ_HOST)) host_rdata <= rdata_q;

      if (spi_load)       spi_pend <= 1'b1;
      else if (grant_spi) spi_pend <= 1'b0;
      if (spi_cmd && spi_pend && !grant_spi) spi_ovr <= 1'b1;

`ifdef RAM_ARB_AUTOINC_EN
      // An explicit address load takes precedence over the post-access increment.
      if (ld_wr)                     wr_addr <= pay_addr;
      else if (grant_spi && !spi_rd) wr_addr <= wr_addr + ADDR_SIZE'(1);
      if (ld_rd)                     rd_addr <= pay_addr;
      else if (grant_spi && spi_rd)  rd_addr <= rd_addr + ADDR_SIZE'(1);
`else
      if (ld_wr) wr_addr <= pay_addr;
      if (ld_rd) rd_addr <= pay_addr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (spi_load) begin
      spi_rd    <= rx_data[9];
      spi_wdata <= rx_data[7:0];
    end
    // Read data is captured in RD_WAIT, the cycle the RAM presents it.
    if (state == ST_RD_WAIT) rdata_q <= mem_dout;
  end

  ram_arb_tx_hold #(.TX_HOLD(TX_HOLD)) u_tx_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (rdata_q),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data)
  );

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural synchronous RAM;
// covers the RAM_ARB_AUTOINC_EN build when that macro is defined.
module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_din;
  logic [7:0] mem_dout = '0;
  logic       spi_ovr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [256];
  logic [7:0] acc_addr[$], acc_din[$];
  logic       acc_we[$], acc_host[$];
  int cyc = 0, tx_cycles, tx_rise, gnt_cyc, rv_cyc, rv_cnt;
  logic [7:0] tx_last, rv_data;
  logic tx_prev;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
    end
  end

  ram_access_arbiter #(.ADDR_SIZE(8), .TX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .spi_ovr(spi_ovr)
  );

  task automatic clear_log();
    acc_addr.delete(); acc_din.delete(); acc_we.delete(); acc_host.delete();
    tx_cycles = 0; tx_rise = -1; gnt_cyc = -1; rv_cyc = -1; rv_cnt = 0;
    tx_last = 8'h00; rv_data = 8'h00; tx_prev = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_en) begin
      acc_addr.push_back(mem_addr); acc_din.push_back(mem_din);
      acc_we.push_back(mem_we);     acc_host.push_back(host_gnt);
    end
    if (tx_valid) begin
      tx_cycles++; tx_last = tx_data;
      if (!tx_prev) tx_rise = cyc;
    end
    tx_prev = tx_valid;
    if (host_gnt) gnt_cyc = cyc;
    if (host_rvalid) begin rv_cnt++; rv_data = host_rdata; rv_cyc = cyc; end
  endtask

  task automatic send(input logic [9:0] w);
    rx_data = w; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_host_gnt(input string name);
    int k = 0;
    while (!host_gnt && k < 20) begin step(); k++; end
    checks++;
    if (!host_gnt) begin
      errors++; $display("FAIL %s host_gnt timeout after %0d cycles", name, k);
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    steps(2);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_din, host_gnt, host_rvalid, host_rdata} !== '0) begin
      errors++; $display("FAIL reset_mem_host got %b required 0",
                         {mem_en, mem_we, mem_addr, mem_din, host_gnt, host_rvalid, host_rdata});
    end
    checks++;
    if ({tx_valid, tx_data, spi_ovr} !== '0) begin
      errors++; $display("FAIL reset_tx_ovr got %b required 0", {tx_valid, tx_data, spi_ovr});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_spi_write();
    clear_log();
    send(10'h005);
    send(10'h1A5);
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 8'h05, 8'hA5}) begin
      errors++; $display("FAIL spi_write_latency got en=%b we=%b addr=%h din=%h required 1 1 05 a5",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    steps(5);
    checks++;
    if (acc_addr.size() != 1) begin
      errors++; $display("FAIL spi_write_count got %0d required 1", acc_addr.size());
    end
  endtask

  task automatic test_spi_read();
    int c0;
    clear_log();
    send(10'h205);
    send(10'h300);
    c0 = cyc;
    steps(14);
    checks++;
    if (tx_rise != c0 + 4) begin
      errors++; $display("FAIL spi_read_latency got rise at +%0d required +4", tx_rise - c0);
    end
    checks++;
    if (tx_cycles != 8 || tx_last !== 8'hA5) begin
      errors++; $display("FAIL spi_read_hold got cycles=%0d data=%h required 8 a5", tx_cycles, tx_last);
    end
    checks++;
    if (acc_addr.size() != 1 || acc_we[0] !== 1'b0 || acc_addr[0] !== 8'h05) begin
      errors++; $display("FAIL spi_read_access got n=%0d required one read at 05", acc_addr.size());
    end
  endtask

  task automatic test_host();
    clear_log();
    host_addr = 8'h20; host_we = 1'b1; host_wdata = 8'h3C; host_req = 1'b1;
    wait_host_gnt("host_write");
    steps(3);
    checks++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 8'h20 || acc_din[0] !== 8'h3C || acc_we[0] !== 1'b1) begin
      errors++; $display("FAIL host_write got n=%0d required one write 3c at 20", acc_addr.size());
    end
    clear_log();
    host_addr = 8'h05; host_we = 1'b0; host_req = 1'b1;
    wait_host_gnt("host_read");
    steps(6);
    checks++;
    if (rv_cyc != gnt_cyc + 3 || rv_cnt != 1 || rv_data !== 8'hA5) begin
      errors++; $display("FAIL host_read got delay=%0d pulses=%0d data=%h required 3 1 a5",
                         rv_cyc - gnt_cyc, rv_cnt, rv_data);
    end
  endtask

  task automatic test_tie();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    clear_log();
    for (int r = 0; r < 3; r++) begin
      rx_data = 10'h150 + 10'(r); rx_valid = 1'b1;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40 + 8'(r); host_wdata = 8'hC0 + 8'(r);
      step();
      rx_valid = 1'b0;
      wait_host_gnt("tie_round");
      steps(2);
    end
    checks++;
    if (acc_host.size() != 6) begin
      errors++; $display("FAIL tie_count got %0d required 6", acc_host.size());
    end
    for (int i = 0; i < acc_host.size() && i < 6; i++) begin
      checks++;
      if (acc_host[i] !== ((i % 2) == 1)) begin
        errors++; $display("FAIL tie_order slot %0d got host=%b required %b", i, acc_host[i], (i % 2) == 1);
      end
    end
  endtask

  task automatic test_overrun();
    int n_spi = 0;
    checks++;
    if (spi_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_before got %b required 0", spi_ovr);
    end
    send(10'h030);
    steps(2);
    clear_log();
    host_addr = 8'h40; host_we = 1'b0; host_req = 1'b1;
    wait_host_gnt("ovr_host");
    rx_data = 10'h177; rx_valid = 1'b1;
    step();
    rx_data = 10'h188;
    step();
    rx_valid = 1'b0;
    steps(8);
    checks++;
    if (spi_ovr !== 1'b1) begin
      errors++; $display("FAIL ovr_flag got %b required 1", spi_ovr);
    end
    for (int i = 0; i < acc_host.size(); i++)
      if (!acc_host[i]) n_spi++;
    checks++;
    if (n_spi != 1 || ram[8'h30] !== 8'h77) begin
      errors++; $display("FAIL ovr_single_write got writes=%0d ram30=%h required 1 77", n_spi, ram[8'h30]);
    end
    checks++;
    if (rv_data !== 8'hC0) begin
      errors++; $display("FAIL ovr_host_read got %h required c0", rv_data);
    end
  endtask

  task automatic test_reset_mid();
    host_addr = 8'h05; host_we = 1'b0; host_req = 1'b1;
    wait_host_gnt("rstmid_host");
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_din, host_gnt, host_rvalid, host_rdata,
         tx_valid, tx_data, spi_ovr} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %b required 0",
                         {mem_en, mem_we, mem_addr, mem_din, host_gnt, host_rvalid, host_rdata,
                          tx_valid, tx_data, spi_ovr});
    end
    clear_log();
    step();
    rst_n = 1'b1;
    steps(6);
    checks++;
    if (rv_cnt != 0 || tx_cycles != 0) begin
      errors++; $display("FAIL rstmid_no_resp got rvalid=%0d tx=%0d required 0 0", rv_cnt, tx_cycles);
    end
    send(10'h205);
    send(10'h300);
    steps(14);
    checks++;
    if (tx_cycles != 8 || tx_last !== 8'hA5) begin
      errors++; $display("FAIL rstmid_resume got cycles=%0d data=%h required 8 a5", tx_cycles, tx_last);
    end
  endtask

  task automatic test_addr_mode();
    logic [7:0] exp [5];
`ifdef RAM_ARB_AUTOINC_EN
    exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12; exp[3] = 8'hFF; exp[4] = 8'h00;
`else
    exp[0] = 8'h10; exp[1] = 8'h10; exp[2] = 8'h10; exp[3] = 8'hFF; exp[4] = 8'hFF;
`endif
    clear_log();
    send(10'h010);
    for (int i = 0; i < 3; i++) begin send(10'h101 + 10'(i)); steps(3); end
    send(10'h0FF);
    for (int i = 0; i < 2; i++) begin send(10'h1E0 + 10'(i)); steps(3); end
    checks++;
    if (acc_addr.size() != 5) begin
      errors++; $display("FAIL addr_mode_count got %0d required 5", acc_addr.size());
    end
    for (int i = 0; i < acc_addr.size() && i < 5; i++) begin
      checks++;
      if (acc_addr[i] !== exp[i]) begin
        errors++; $display("FAIL addr_mode write %0d got %h required %h", i, acc_addr[i], exp[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    clear_log();
    test_reset();
    test_spi_write();
    test_spi_read();
    test_host();
    test_tie();
    test_overrun();
    test_reset_mid();
    test_addr_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, RAM address width; the RAM depth is 2**ADDR_SIZE.
REQ-002 SHALL have parameter TX_HOLD, default 8, number of cycles tx_valid and tx_data are held for the SPI slave to shift out.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rx_data  in  10  SPI slave word; [9:8] is the command, [7:0] is the payload.
REQ-006 rx_valid  in  1  one-cycle pulse qualifying rx_data.
REQ-007 tx_data  out  8  read data returned to the SPI slave.
REQ-008 tx_valid  out  1  tx_data valid and held stable.
REQ-009 host_req, host_we  in  1 each  local host access request and write-enable.
REQ-010 host_addr / host_wdata  in  ADDR_SIZE / 8  host address and write data; the host holds them until granted.
REQ-011 host_gnt  out  1  one-cycle pulse marking the cycle the host access is issued.
REQ-012 host_rvalid / host_rdata  out  1 / 8  one-cycle pulse plus host read data.
REQ-013 mem_en, mem_we  out  1 each  RAM port enable and write-enable.
REQ-014 mem_addr / mem_din  out  ADDR_SIZE / 8  RAM address and write data.
REQ-015 mem_dout  in  8  RAM read data, valid one cycle after the read access cycle.
REQ-016 spi_ovr  out  1  sticky SPI overrun flag.

Function
REQ-017 SHALL decode rx_data[9:8] on rx_valid as follows:
- 00: load wr_addr (no RAM access).
- 01: SPI write of the payload to wr_addr.
- 10: load rd_addr (no RAM access).
- 11: SPI read at rd_addr; the payload is ignored.
REQ-018 SHALL hold one SPI pending entry, set on a 01/11 command; it is cleared on grant and may be reloaded on the same edge it is cleared.
REQ-019 A 01/11 command arriving while the pending entry is already full and not being granted SHALL be dropped and SHALL set spi_ovr; spi_ovr clears only on reset.
REQ-020 State machine SHALL have states IDLE, ACCESS, RD_WAIT, RESP:
- IDLE -> ACCESS when any request is pending.
- ACCESS -> RD_WAIT for a read; ACCESS -> IDLE for a write.
- RD_WAIT -> RESP.
- RESP -> IDLE.
REQ-021 mem_en SHALL be high only in ACCESS, for exactly one cycle, with mem_we/mem_addr/mem_din registered at grant; all are 0 in every other state.
REQ-022 Arbitration SHALL be round-robin: when both are pending, grant the requester not granted last; a lone requester is granted immediately; last-granted resets to HOST, so SPI wins the first tie.
REQ-023 The address and data used for a grant SHALL be captured at grant; later 00/10 commands update the latches without affecting an access in flight.
REQ-024 In RESP, an SPI read SHALL load tx_data from mem_dout and assert tx_valid for exactly TX_HOLD cycles; a new SPI read result restarts the hold.
REQ-025 In RESP, a host read SHALL set host_rdata = mem_dout with host_rvalid high for one cycle.
REQ-026 host_gnt SHALL pulse in the ACCESS cycle of a host grant.
REQ-027 Latencies:
- SPI write: rx_valid sampled at edge E drives mem_en high in cycle E+1..E+2.
- SPI read: tx_valid rises at edge E+4 when the arbiter is idle.
- Host read: host_rvalid rises 3 cycles after host_gnt.
REQ-028 Addresses SHALL be ADDR_SIZE wide; when ADDR_SIZE < 8, payload bits above ADDR_SIZE are ignored.

Reset
REQ-029 rst_n low SHALL asynchronously force:
- state IDLE; pending cleared; wr_addr and rd_addr 0; last-granted HOST.
- all outputs 0, including spi_ovr and tx_data.
REQ-030 Reset mid-access SHALL abandon the access with no response pulse; operation resumes on the first edge after release.

Configuration
REQ-031 With macro RAM_ARB_AUTOINC_EN defined:
- wr_addr SHALL increment modulo 2**ADDR_SIZE on each granted SPI write.
- rd_addr SHALL increment modulo 2**ADDR_SIZE on each granted SPI read.
- An increment coinciding with a 00/10 load SHALL yield the loaded value.
REQ-032 Without RAM_ARB_AUTOINC_EN, addresses SHALL change only on 00/10 commands.

Structure
REQ-033 Package ram_arb_pkg SHALL hold the command encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), the state encoding and the requester ID constants.
REQ-034 The TX_HOLD counter SHALL be a sub-module, ram_arb_tx_hold, with load, tx_valid and tx_data ports.

Verification
REQ-035 SPI write: rx 0x005 then 0x1A5 -> one mem_en/mem_we cycle with addr 0x05, din 0xA5.
REQ-036 SPI read: RAM[0x05]=0xA5; rx 0x205 then 0x300 -> tx_data 0xA5, tx_valid high exactly 8 cycles.
REQ-037 Tie: SPI 01 and host_req arrive in the same cycle, repeated 3 times -> grants alternate SPI, HOST, SPI, HOST, SPI, HOST.
REQ-038 Overrun: two 01 commands on consecutive cycles while a host access is in ACCESS -> second dropped, spi_ovr=1, one SPI write only.
REQ-039 Autoinc (macro on): wr_addr 0x10, three 01 writes -> addrs 0x10, 0x11, 0x12; 0xFF wraps to 0x00.
REQ-040 Reset asserted in RD_WAIT -> no tx_valid/host_rvalid; all outputs 0 immediately; next request served normally.
